// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_stage_pkg
//  Purpose : Shared definitions for the memory-stage controller: FSM state
//            encoding, byte write-enable codes and the default bus timeout.
//  Ports   : (package, none)
//  Rev     : 1.0  initial release
// ============================================================================
package mem_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [1:0] WREN_NONE = 2'b00;
   localparam logic [1:0] WREN_LO   = 2'b01;
   localparam logic [1:0] WREN_HI   = 2'b10;
   localparam logic [1:0] WREN_BOTH = 2'b11;

   localparam int DEFAULT_TIMEOUT = 255;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/call_stack_lifo.sv
`default_nettype none
// ============================================================================
//  Module  : call_stack_lifo
//  Purpose : Call-stack LIFO with occupancy counter. Push when full and pop
//            when empty are ignored; the caller sees full/empty to flag them.
//  Ports   : clock, reset        - clock, async active-high reset
//            push, pop           - single-cycle operation strobes
//            push_data           - value to push
//            full, empty         - occupancy status
//            top_data            - current top entry, 0 when empty
//  Rev     : 1.0  initial release
// ============================================================================
module call_stack_lifo #(
   parameter int CS_DEPTH   = 16,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  full,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] top_data
);

   // CS_DEPTH must be a power of two >= 2; the counter has one extra bit so
   // that "full" (count == CS_DEPTH) is representable.
   localparam int IDX_W = $clog2(CS_DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam logic [PTR_W-1:0] C_DEPTH = PTR_W'(CS_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [CS_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [CS_DEPTH];
   logic [PTR_W-1:0]      count_q, count_d;
   logic [PTR_W-1:0]      count_dec;
   logic [IDX_W-1:0]      top_idx;
   logic [IDX_W-1:0]      wr_idx;

   assign full      = (count_q == C_DEPTH);
   assign empty     = (count_q == '0);
   assign count_dec = count_q - PTR_W'(1);
   assign top_idx   = count_dec[IDX_W-1:0];
   assign wr_idx    = count_q[IDX_W-1:0];
   assign top_data  = empty ? '0 : mem_q[top_idx];

   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      if (push && !full) begin
         mem_d[wr_idx] = push_data;
         count_d       = count_q + PTR_W'(1);
      end else if (pop && !empty) begin
         count_d = count_dec;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_q   <= '{default: '0};
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         count_q <= count_d;
      end
   end

endmodule : call_stack_lifo
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : mem_stage_ctrl
//  Purpose : Memory-stage access controller. Arbitrates main memory (handshaked,
//            multi-cycle, with timeout), frame buffer (single-cycle write) and
//            an internal call stack; returns load data toward MEM/WB.
//  Ports   : clock, reset                 - clock, async active-high reset
//            mem_wren, *_enable, addr_in, store_data_in - EX/MEM controls
//            mm_req/we/addr/wdata, mm_rdata, mm_ack      - main-memory bus
//            fb_we/addr/wdata             - frame-buffer write port
//            load_data, load_valid        - result to MEM/WB
//            mem_stall                    - hold request to hazard unit
//            bus_error, cs_overflow, cs_underflow - status
//  Rev     : 1.0  initial release
// ============================================================================
module mem_stage_ctrl
   import mem_stage_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int CS_DEPTH   = 16,
   parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [1:0]            mem_wren,
   input  logic                  main_memory_enable,
   input  logic                  frame_buffer_enable,
   input  logic                  call_stack_enable,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] store_data_in,
   output logic                  mm_req,
   output logic [1:0]            mm_we,
   output logic [ADDR_WIDTH-1:0] mm_addr,
   output logic [DATA_WIDTH-1:0] mm_wdata,
   input  logic [DATA_WIDTH-1:0] mm_rdata,
   input  logic                  mm_ack,
   output logic [1:0]            fb_we,
   output logic [ADDR_WIDTH-1:0] fb_addr,
   output logic [DATA_WIDTH-1:0] fb_wdata,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_valid,
   output logic                  mem_stall,
   output logic                  bus_error,
   output logic                  cs_overflow,
   output logic                  cs_underflow
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
   logic                  mm_req_q, mm_req_d;
   logic [1:0]            mm_we_q, mm_we_d;
   logic [ADDR_WIDTH-1:0] mm_addr_q, mm_addr_d;
   logic [DATA_WIDTH-1:0] mm_wdata_q, mm_wdata_d;
   logic [1:0]            fb_we_q, fb_we_d;
   logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
   logic [DATA_WIDTH-1:0] fb_wdata_q, fb_wdata_d;
   logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
   logic                  load_valid_q, load_valid_d;
   logic                  bus_error_q, bus_error_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;

   logic                  cs_push, cs_pop, cs_full, cs_empty;
   logic [DATA_WIDTH-1:0] cs_top;

   call_stack_lifo #(
      .CS_DEPTH   (CS_DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_call_stack (
      .clock     (clock),
      .reset     (reset),
      .push      (cs_push),
      .pop       (cs_pop),
      .push_data (store_data_in),
      .full      (cs_full),
      .empty     (cs_empty),
      .top_data  (cs_top)
   );

   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mm_req_d     = mm_req_q;
      mm_we_d      = mm_we_q;
      mm_addr_d    = mm_addr_q;
      mm_wdata_d   = mm_wdata_q;
      fb_we_d      = WREN_NONE;
      fb_addr_d    = fb_addr_q;
      fb_wdata_d   = fb_wdata_q;
      load_data_d  = load_data_q;
      load_valid_d = 1'b0;
      bus_error_d  = 1'b0;
      ovf_d        = ovf_q;
      unf_d        = unf_q;
      cs_push      = 1'b0;
      cs_pop       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Fixed priority: main memory, then frame buffer, then call stack.
            if (main_memory_enable) begin
               state_d    = ST_BUSY;
               cnt_d      = '0;
               mm_req_d   = 1'b1;
               mm_we_d    = mem_wren;
               mm_addr_d  = addr_in;
               mm_wdata_d = store_data_in;
            end else if (frame_buffer_enable) begin
               if (mem_wren != WREN_NONE) begin
                  fb_we_d    = mem_wren;
                  fb_addr_d  = addr_in;
                  fb_wdata_d = store_data_in;
               end
            end else if (call_stack_enable) begin
               if (mem_wren != WREN_NONE) begin
                  cs_push = 1'b1;
                  if (cs_full) ovf_d = 1'b1;
               end else begin
                  // cs_top already reads 0 when the stack is empty.
                  cs_pop       = 1'b1;
                  load_data_d  = cs_top;
                  load_valid_d = 1'b1;
                  if (cs_empty) unf_d = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_inc;
            // Ack is checked first so an ack on the timeout cycle still wins.
            if (mm_ack) begin
               mm_req_d = 1'b0;
               state_d  = ST_DONE;
               if (mm_we_q == WREN_NONE) begin
                  load_data_d  = mm_rdata;
                  load_valid_d = 1'b1;
               end
            end else if (cnt_inc == C_TIMEOUT) begin
               mm_req_d     = 1'b0;
               state_d      = ST_DONE;
               load_data_d  = '1;
               bus_error_d  = 1'b1;
               load_valid_d = (mm_we_q == WREN_NONE);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         mm_req_q     <= 1'b0;
         mm_we_q      <= WREN_NONE;
         mm_addr_q    <= '0;
         mm_wdata_q   <= '0;
         fb_we_q      <= WREN_NONE;
         fb_addr_q    <= '0;
         fb_wdata_q   <= '0;
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
         bus_error_q  <= 1'b0;
         ovf_q        <= 1'b0;
         unf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mm_req_q     <= mm_req_d;
         mm_we_q      <= mm_we_d;
         mm_addr_q    <= mm_addr_d;
         mm_wdata_q   <= mm_wdata_d;
         fb_we_q      <= fb_we_d;
         fb_addr_q    <= fb_addr_d;
         fb_wdata_q   <= fb_wdata_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         bus_error_q  <= bus_error_d;
         ovf_q        <= ovf_d;
         unf_q        <= unf_d;
      end
   end

   // Stall is combinational so EX/MEM freezes in the same cycle the request
   // appears; gated by reset so every output reads 0 while reset is held.
   assign mem_stall = !reset &&
                      (((state_q == ST_IDLE) && main_memory_enable) || (state_q == ST_BUSY));

   assign mm_req       = mm_req_q;
   assign mm_we        = mm_we_q;
   assign mm_addr      = mm_addr_q;
   assign mm_wdata     = mm_wdata_q;
   assign fb_we        = fb_we_q;
   assign fb_addr      = fb_addr_q;
   assign fb_wdata     = fb_wdata_q;
   assign load_data    = load_data_q;
   assign load_valid   = load_valid_q;
   assign bus_error    = bus_error_q;
   assign cs_overflow  = ovf_q;
   assign cs_underflow = unf_q;

endmodule : mem_stage_ctrl
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_stage_ctrl
//  Purpose : Self-checking bench for mem_stage_ctrl with directed scenarios and
//            randomized traffic against a queue-based reference model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mem_stage_ctrl;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int DEPTH = 16;
   localparam int TO = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic [1:0]    mem_wren;
   logic          main_memory_enable, frame_buffer_enable, call_stack_enable;
   logic [AW-1:0] addr_in;
   logic [DW-1:0] store_data_in;
   logic          mm_req;
   logic [1:0]    mm_we;
   logic [AW-1:0] mm_addr;
   logic [DW-1:0] mm_wdata;
   logic [DW-1:0] mm_rdata;
   logic          mm_ack;
   logic [1:0]    fb_we;
   logic [AW-1:0] fb_addr;
   logic [DW-1:0] fb_wdata;
   logic [DW-1:0] load_data;
   logic          load_valid, mem_stall, bus_error, cs_overflow, cs_underflow;

   mem_stage_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .CS_DEPTH   (DEPTH),
      .TIMEOUT    (TO)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .mem_wren            (mem_wren),
      .main_memory_enable  (main_memory_enable),
      .frame_buffer_enable (frame_buffer_enable),
      .call_stack_enable   (call_stack_enable),
      .addr_in             (addr_in),
      .store_data_in       (store_data_in),
      .mm_req              (mm_req),
      .mm_we               (mm_we),
      .mm_addr             (mm_addr),
      .mm_wdata            (mm_wdata),
      .mm_rdata            (mm_rdata),
      .mm_ack              (mm_ack),
      .fb_we               (fb_we),
      .fb_addr             (fb_addr),
      .fb_wdata            (fb_wdata),
      .load_data           (load_data),
      .load_valid          (load_valid),
      .mem_stall           (mem_stall),
      .bus_error           (bus_error),
      .cs_overflow         (cs_overflow),
      .cs_underflow        (cs_underflow)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DW-1:0] stack_m[$];
   logic [DW-1:0] exp_load = '0;
   logic          exp_ovf  = 1'b0;
   logic          exp_unf  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      main_memory_enable  = 1'b0;
      frame_buffer_enable = 1'b0;
      call_stack_enable   = 1'b0;
      mem_wren            = 2'b00;
   endtask

   // Main-memory access. With ack, mm_ack is raised in BUSY cycle 'dly'
   // (0-based); without ack the access should abort after TO BUSY cycles.
   task automatic mm_access(input logic [15:0] a, input logic [1:0] we,
                            input logic [15:0] wd, input bit ack, input int dly,
                            input logic [15:0] rd);
      int n;
      main_memory_enable  = 1'b1;
      frame_buffer_enable = 1'b1;   // lower priority, must be ignored
      call_stack_enable   = 1'b1;   // lower priority, must be ignored
      mem_wren            = we;
      addr_in             = a;
      store_data_in       = wd;
      #1;
      check("stall_idle", mem_stall, 1);
      tick();
      check("fb_ignored", fb_we, 0);
      check("mm_addr", mm_addr, a);
      check("mm_we", mm_we, we);
      check("mm_wdata", mm_wdata, wd);
      n = ack ? dly + 1 : TO;
      for (int k = 0; k < n; k++) begin
         check("mm_req_busy", mm_req, 1);
         check("stall_busy", mem_stall, 1);
         if (ack && k == dly) begin
            mm_ack   = 1'b1;
            mm_rdata = rd;
         end
         tick();
         mm_ack   = 1'b0;
         mm_rdata = DW'($urandom);
      end
      idle_inputs();
      #1;
      if (!ack) exp_load = '1;
      else if (we == 2'b00) exp_load = rd;
      check("done_mm_req", mm_req, 0);
      check("done_stall", mem_stall, 0);
      check("done_load_valid", load_valid, (we == 2'b00));
      check("done_bus_error", bus_error, !ack);
      check("done_load_data", load_data, exp_load);
      tick();
      check("after_done_valid", load_valid, 0);
      check("after_done_error", bus_error, 0);
      check("after_done_req", mm_req, 0);
   endtask

   task automatic fb_op(input logic [15:0] a, input logic [1:0] we,
                        input logic [15:0] d, input bit cs_too);
      frame_buffer_enable = 1'b1;
      call_stack_enable   = cs_too;
      mem_wren            = we;
      addr_in             = a;
      store_data_in       = d;
      #1;
      check("fb_stall", mem_stall, 0);
      tick();
      idle_inputs();
      check("fb_we", fb_we, we);
      if (we != 2'b00) begin
         check("fb_addr", fb_addr, a);
         check("fb_wdata", fb_wdata, d);
      end
      check("fb_no_load_valid", load_valid, 0);
      tick();
      check("fb_we_pulse_end", fb_we, 0);
   endtask

   task automatic cs_op(input logic [1:0] we, input logic [15:0] d);
      call_stack_enable = 1'b1;
      mem_wren          = we;
      store_data_in     = d;
      #1;
      check("cs_stall", mem_stall, 0);
      tick();
      idle_inputs();
      if (we != 2'b00) begin
         if (stack_m.size() < DEPTH) stack_m.push_back(d);
         else exp_ovf = 1'b1;
         check("push_load_valid", load_valid, 0);
      end else begin
         if (stack_m.size() > 0) exp_load = stack_m.pop_back();
         else begin
            exp_load = '0;
            exp_unf  = 1'b1;
         end
         check("pop_load_valid", load_valid, 1);
         check("pop_load_data", load_data, exp_load);
      end
      check("cs_overflow", cs_overflow, exp_ovf);
      check("cs_underflow", cs_underflow, exp_unf);
      tick();
      check("cs_valid_pulse_end", load_valid, 0);
   endtask

   initial begin
      reset         = 1'b1;
      idle_inputs();
      main_memory_enable = 1'b1;
      addr_in       = '0;
      store_data_in = '0;
      mm_rdata      = '0;
      mm_ack        = 1'b0;
      #3;
      check("rst_mm_req", mm_req, 0);
      check("rst_stall", mem_stall, 0);
      check("rst_load_data", load_data, 0);
      check("rst_load_valid", load_valid, 0);
      check("rst_fb_we", fb_we, 0);
      check("rst_flags", {bus_error, cs_overflow, cs_underflow}, 0);
      idle_inputs();
      tick();
      reset = 1'b0;
      tick();

      // Directed: read with ack in the third BUSY cycle (4 stall cycles)
      mm_access(16'h1234, 2'b00, 16'h0000, 1'b1, 2, 16'hBEEF);
      // Directed: low-byte write with immediate ack
      mm_access(16'h0042, 2'b01, 16'hA55A, 1'b1, 0, 16'h1111);
      // Directed: timeout, read
      mm_access(16'h0BAD, 2'b00, 16'h0000, 1'b0, 0, 16'h0000);
      // Ack on the final allowed cycle must beat the timeout
      mm_access(16'h0777, 2'b00, 16'h0000, 1'b1, TO - 1, 16'h5A5A);

      // Frame buffer writes, no-op read, priority over call stack
      fb_op(16'h2000, 2'b11, 16'hCAFE, 1'b0);
      fb_op(16'h2001, 2'b00, 16'h1234, 1'b0);
      fb_op(16'h2002, 2'b10, 16'h00FF, 1'b1);

      // Stack: push 0x0100, 0x0200; pop three times (last underflows)
      cs_op(2'b11, 16'h0100);
      cs_op(2'b01, 16'h0200);
      cs_op(2'b00, 16'h0000);
      cs_op(2'b00, 16'h0000);
      cs_op(2'b00, 16'h0000);

      // 17 pushes into a 16-deep stack; the 17th is dropped
      for (int i = 1; i <= DEPTH + 1; i++) cs_op(2'b11, 16'(i * 16'h0101));
      cs_op(2'b00, 16'h0000);

      // Randomized mixed traffic
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 4))
            0: cs_op(2'($urandom_range(1, 3)), DW'($urandom));
            1: cs_op(2'b00, 16'h0000);
            2: fb_op(AW'($urandom), 2'($urandom_range(0, 3)), DW'($urandom),
                     1'($urandom_range(0, 1)));
            3: mm_access(AW'($urandom), 2'b00, DW'($urandom),
                         ($urandom_range(0, 3) != 0), $urandom_range(0, TO - 1),
                         DW'($urandom));
            default: mm_access(AW'($urandom), 2'($urandom_range(1, 3)), DW'($urandom),
                               ($urandom_range(0, 3) != 0), $urandom_range(0, TO - 1),
                               DW'($urandom));
         endcase
      end

      // Reset asserted in the middle of a BUSY read
      main_memory_enable = 1'b1;
      mem_wren           = 2'b00;
      addr_in            = 16'h4321;
      tick();
      tick();
      check("busy_before_reset", mm_req, 1);
      #1;
      reset = 1'b1;
      #1;
      check("async_rst_mm_req", mm_req, 0);
      check("async_rst_stall", mem_stall, 0);
      check("async_rst_load_data", load_data, 0);
      check("async_rst_flags", {bus_error, cs_overflow, cs_underflow, load_valid}, 0);
      #2;
      reset = 1'b0;
      idle_inputs();
      stack_m.delete();
      exp_load = '0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
      tick();
      check("discarded_mm_req", mm_req, 0);
      check("discarded_stall", mem_stall, 0);
      cs_op(2'b00, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog: the directed sequence is bounded, this only guards a hang.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_mem_stage_ctrl
`default_nettype wire
